// File: rtl/alu_sweep_ctrl.sv
// Sweeps every (op, A, B) vector of a 3-bit signed ALU, captures each result
// into a valid/ready record stream and counts records and divide-by-zero hits.
module alu_sweep_ctrl #(
   parameter int unsigned OP_FIRST = 0,
   parameter int unsigned OP_LAST  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       out_ready,
   output logic [2:0] alu_a,
   output logic [2:0] alu_b,
   output logic [1:0] alu_s,
   input  logic [4:0] alu_r,
   input  logic       alu_sf,
   input  logic       alu_zf,
   input  logic       alu_dzf,
   output logic       out_valid,
   output logic [2:0] out_a,
   output logic [2:0] out_b,
   output logic [1:0] out_s,
   output logic [4:0] out_r,
   output logic [2:0] out_flags,
   output logic       busy,
   output logic       done,
   output logic [7:0] vec_count,
   output logic [3:0] dz_count
);

   localparam int unsigned SW = 2;
   localparam int unsigned DW = 3;
   localparam int unsigned RW = 5;
   localparam int unsigned FW = 3;
   localparam int unsigned CW = 8;
   localparam int unsigned ZW = 4;

   localparam logic [SW-1:0] S_FIRST = SW'(OP_FIRST);
   localparam logic [SW-1:0] S_LAST  = SW'(OP_LAST);
   localparam logic [DW-1:0] V_MIN   = 3'b101;
   localparam logic [DW-1:0] V_MAX   = 3'b011;
   localparam logic [ZW-1:0] DZ_MAX  = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_HOLD, ST_DONE} state_e;

   state_e state_q, state_d;

   logic [SW-1:0] s_q, s_d;
   logic [DW-1:0] a_q, a_d, b_q, b_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
   logic [SW-1:0] out_s_q, out_s_d;
   logic [RW-1:0] out_r_q, out_r_d;
   logic [FW-1:0] out_flags_q, out_flags_d;
   logic [CW-1:0] vec_q, vec_d;
   logic [ZW-1:0] dz_q, dz_d;

   logic load, capture, hs, last_vec;

   assign load     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
   assign capture  = (state_q == ST_DRIVE);
   assign hs       = (state_q == ST_HOLD) && out_valid_q && out_ready;
   assign last_vec = (s_q == S_LAST) && (a_q == V_MAX) && (b_q == V_MAX);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_DRIVE;
         ST_DRIVE:         state_d = ST_HOLD;
         ST_HOLD:          if (hs) state_d = last_vec ? ST_DONE : ST_DRIVE;
         default:          state_d = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      busy  = 1'b0;
      done  = 1'b0;
      alu_a = '0;
      alu_b = '0;
      alu_s = '0;
      case (state_q)
         ST_DRIVE, ST_HOLD: begin
            busy  = 1'b1;
            alu_a = a_q;
            alu_b = b_q;
            alu_s = s_q;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Vector stepping, record capture and counters; B wraps into A, A into S
   always_comb begin
      s_d         = s_q;
      a_d         = a_q;
      b_d         = b_q;
      out_valid_d = out_valid_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_s_d     = out_s_q;
      out_r_d     = out_r_q;
      out_flags_d = out_flags_q;
      vec_d       = vec_q;
      dz_d        = dz_q;
      if (load) begin
         s_d   = S_FIRST;
         a_d   = V_MIN;
         b_d   = V_MIN;
         vec_d = '0;
         dz_d  = '0;
      end
      if (capture) begin
         out_valid_d = 1'b1;
         out_a_d     = a_q;
         out_b_d     = b_q;
         out_s_d     = s_q;
         out_r_d     = alu_r;
         out_flags_d = {alu_sf, alu_zf, alu_dzf};
      end
      if (hs) begin
         out_valid_d = 1'b0;
         vec_d       = vec_q + CW'(1);
         if (out_flags_q[0] && (dz_q != DZ_MAX)) dz_d = dz_q + ZW'(1);
         if (b_q == V_MAX) begin
            b_d = V_MIN;
            if (a_q == V_MAX) begin
               a_d = V_MIN;
               s_d = s_q + SW'(1);
            end else begin
               a_d = a_q + DW'(1);
            end
         end else begin
            b_d = b_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_s_q     <= '0;
         out_r_q     <= '0;
         out_flags_q <= '0;
         vec_q       <= '0;
         dz_q        <= '0;
      end else begin
         s_q         <= s_d;
         a_q         <= a_d;
         b_q         <= b_d;
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_s_q     <= out_s_d;
         out_r_q     <= out_r_d;
         out_flags_q <= out_flags_d;
         vec_q       <= vec_d;
         dz_q        <= dz_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_s     = out_s_q;
   assign out_r     = out_r_q;
   assign out_flags = out_flags_q;
   assign vec_count = vec_q;
   assign dz_count  = dz_q;

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Bench for alu_sweep_ctrl: a behavioural ALU feeds two controllers (full sweep
// and single-op sweep); records are checked against a scoreboard queue.
module tb_alu_sweep_ctrl;

   typedef struct packed {
      logic [1:0] s;
      logic [2:0] a;
      logic [2:0] b;
      logic [4:0] r;
      logic [2:0] f;
   } rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_v   [2];
   logic       ready_v   [2];
   logic [2:0] alu_a_v   [2];
   logic [2:0] alu_b_v   [2];
   logic [1:0] alu_s_v   [2];
   logic [4:0] alu_r_v   [2];
   logic       sf_v      [2];
   logic       zf_v      [2];
   logic       dzf_v     [2];
   logic       ov_v      [2];
   logic [2:0] oa_v      [2];
   logic [2:0] ob_v      [2];
   logic [1:0] os_v      [2];
   logic [4:0] or_v      [2];
   logic [2:0] of_v      [2];
   logic       busy_v    [2];
   logic       done_v    [2];
   logic [7:0] vec_v     [2];
   logic [3:0] dz_v      [2];

   int   total = 0;
   int   bad   = 0;
   int   sel   = 0;
   rec_t exp_q[$];

   // Reference ALU: {result, SF, ZF, DZF}; remainder by zero yields 0
   function automatic logic [7:0] alu_model(input logic [1:0] s, input logic [2:0] a,
                                            input logic [2:0] b);
      int ia, ib, ir;
      logic [4:0] r;
      ia = int'($signed(a));
      ib = int'($signed(b));
      case (s)
         2'd0:    ir = ia + ib;
         2'd1:    ir = ia - ib;
         2'd2:    ir = ia * ib;
         default: ir = (ib == 0) ? 0 : ia % ib;
      endcase
      r = 5'(ir);
      return {r, r[4], (r == 5'd0), (s == 2'd3) && (ib == 0)};
   endfunction

   assign {alu_r_v[0], sf_v[0], zf_v[0], dzf_v[0]} = alu_model(alu_s_v[0], alu_a_v[0], alu_b_v[0]);
   assign {alu_r_v[1], sf_v[1], zf_v[1], dzf_v[1]} = alu_model(alu_s_v[1], alu_a_v[1], alu_b_v[1]);

   alu_sweep_ctrl u_dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .out_ready(ready_v[0]),
      .alu_a(alu_a_v[0]), .alu_b(alu_b_v[0]), .alu_s(alu_s_v[0]), .alu_r(alu_r_v[0]),
      .alu_sf(sf_v[0]), .alu_zf(zf_v[0]), .alu_dzf(dzf_v[0]),
      .out_valid(ov_v[0]), .out_a(oa_v[0]), .out_b(ob_v[0]), .out_s(os_v[0]),
      .out_r(or_v[0]), .out_flags(of_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .vec_count(vec_v[0]), .dz_count(dz_v[0])
   );

   alu_sweep_ctrl #(.OP_FIRST(3), .OP_LAST(3)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .out_ready(ready_v[1]),
      .alu_a(alu_a_v[1]), .alu_b(alu_b_v[1]), .alu_s(alu_s_v[1]), .alu_r(alu_r_v[1]),
      .alu_sf(sf_v[1]), .alu_zf(zf_v[1]), .alu_dzf(dzf_v[1]),
      .out_valid(ov_v[1]), .out_a(oa_v[1]), .out_b(ob_v[1]), .out_s(os_v[1]),
      .out_r(or_v[1]), .out_flags(of_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .vec_count(vec_v[1]), .dz_count(dz_v[1])
   );

   rec_t        obs_rec;
   logic [38:0] obs_all;
   logic [7:0]  obs_alu;
   always_comb begin
      obs_rec = {os_v[sel], oa_v[sel], ob_v[sel], or_v[sel], of_v[sel]};
      obs_alu = {alu_s_v[sel], alu_a_v[sel], alu_b_v[sel]};
      obs_all = {ov_v[sel], obs_rec, busy_v[sel], done_v[sel], vec_v[sel], dz_v[sel], obs_alu};
   end

   task automatic push_sweep(input int first, input int last);
      rec_t e;
      for (int s = first; s <= last; s++)
         for (int a = -3; a <= 3; a++)
            for (int b = -3; b <= 3; b++) begin
               e.s = 2'(s);
               e.a = 3'(a);
               e.b = 3'(b);
               {e.r, e.f} = alu_model(e.s, e.a, e.b);
               exp_q.push_back(e);
            end
   endtask

   task automatic pop_check(input string tag, input int idx);
      rec_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s[%0d]: got record %h, scoreboard empty", tag, idx, obs_rec);
      end else begin
         e = exp_q.pop_front();
         if (obs_rec !== e) begin
            bad++;
            $display("FAIL %s[%0d]: got record %h want %h", tag, idx, obs_rec, e);
         end
      end
   endtask

   task automatic pulse_start(input int s);
      @(negedge clk);
      start_v[s] = 1'b1;
      @(negedge clk);
      start_v[s] = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      start_v[0] = 1'b0; start_v[1] = 1'b0;
      ready_v[0] = 1'b0; ready_v[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Consume records until done; optional timing, DZF/B and fixed-index checks
   task automatic collect(input int n_exp, input bit inject, input bit timing,
                          input bit dzb, input bit fixed_idx);
      int n = 0, cyc = 0, last_cyc = 0;
      logic [7:0] sab;
      while (cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (done_v[sel]) break;
         if (inject) start_v[sel] = 1'($urandom_range(0, 1));
         if (ov_v[sel] && ready_v[sel]) begin
            pop_check("record", n);
            sab = {obs_rec.s, obs_rec.a, obs_rec.b};
            if (timing) begin
               total++;
               if ((n == 0 && cyc != 1) || (n > 0 && cyc - last_cyc != 2)) begin
                  bad++;
                  $display("FAIL spacing[%0d]: got cycle %0d (prev %0d)", n, cyc, last_cyc);
               end
            end
            if (dzb) begin
               total++;
               if (obs_rec.f[0] !== (obs_rec.b == 3'b000)) begin
                  bad++;
                  $display("FAIL dzf_vs_b[%0d]: got dzf=%b b=%b", n, obs_rec.f[0], obs_rec.b);
               end
            end
            if (fixed_idx && (n == 0 || n == 49 || n == 195)) begin
               total++;
               if ((n == 0   && sab !== 8'b00_101_101) ||
                   (n == 49  && sab !== 8'b01_101_101) ||
                   (n == 195 && sab !== 8'b11_011_011)) begin
                  bad++;
                  $display("FAIL fixed_vec[%0d]: got s/a/b %b", n, sab);
               end
            end
            last_cyc = cyc;
            n++;
         end
      end
      start_v[sel] = 1'b0;
      total++;
      if (cyc >= 2000) begin
         bad++;
         $display("FAIL sweep_timeout: got no done after %0d cycles", cyc);
      end
      total++;
      if (n != n_exp) begin
         bad++;
         $display("FAIL record_count: got %0d want %0d", n, n_exp);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_left: got %0d unconsumed want 0", exp_q.size());
      end
   endtask

   task automatic check_done(input logic [7:0] vec_exp, input logic [3:0] dz_exp);
      logic [22:0] got, want;
      got  = {done_v[sel], busy_v[sel], ov_v[sel], vec_v[sel], dz_v[sel], obs_alu};
      want = {1'b1, 1'b0, 1'b0, vec_exp, dz_exp, 8'h00};
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL done_state: got %h want %h", got, want);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_v[0] = 1'b0; start_v[1] = 1'b0;
      ready_v[0] = 1'b1; ready_v[1] = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         sel = i;
         #1;
         total++;
         if (obs_all !== 39'd0) begin
            bad++;
            $display("FAIL reset_outputs[%0d]: got %h want 0", i, obs_all);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      sel = 0;
      #1;
      total++;
      if (obs_all !== 39'd0) begin
         bad++;
         $display("FAIL idle_outputs: got %h want 0", obs_all);
      end
      ready_v[0] = 1'b0; ready_v[1] = 1'b0;
   endtask

   task automatic test_full_sweep();
      logic [9:0] got;
      sel = 0;
      ready_v[0] = 1'b1;
      push_sweep(0, 3);
      pulse_start(0);
      got = {busy_v[0], ov_v[0], obs_alu};
      total++;
      if (got !== {1'b1, 1'b0, 8'b00_101_101}) begin
         bad++;
         $display("FAIL drive_first: got %b want 1000101101", got);
      end
      collect(196, 1'b0, 1'b1, 1'b0, 1'b1);
      check_done(8'hC4, 4'd7);
   endtask

   task automatic test_start_ignored();
      sel = 0;
      ready_v[0] = 1'b1;
      push_sweep(0, 3);
      pulse_start(0);
      collect(196, 1'b1, 1'b0, 1'b0, 1'b1);
      check_done(8'hC4, 4'd7);
   endtask

   task automatic test_stall();
      rec_t       snap;
      logic [7:0] snap_alu;
      sel = 0;
      apply_reset();
      push_sweep(0, 3);
      pulse_start(0);
      @(negedge clk);
      snap     = obs_rec;
      snap_alu = obs_alu;
      pop_check("stall_first", 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if ({obs_rec, obs_alu, vec_v[0], ov_v[0]} !== {snap, snap_alu, 8'd0, 1'b1}) begin
            bad++;
            $display("FAIL stall_hold[%0d]: got %h/%h vec=%0d v=%b want %h/%h vec=0 v=1",
                     i, obs_rec, obs_alu, vec_v[0], ov_v[0], snap, snap_alu);
         end
      end
      ready_v[0] = 1'b1;
      @(negedge clk);
      ready_v[0] = 1'b0;
      total++;
      if ({vec_v[0], ov_v[0], obs_alu} !== {8'd1, 1'b0, 8'b00_101_110}) begin
         bad++;
         $display("FAIL stall_release: got vec=%0d v=%b alu=%b want vec=1 v=0 alu=00101110",
                  vec_v[0], ov_v[0], obs_alu);
      end
      @(negedge clk);
      pop_check("stall_next", 1);
      @(negedge clk);
      total++;
      if ({vec_v[0], ov_v[0]} !== {8'd1, 1'b1}) begin
         bad++;
         $display("FAIL stall_single_step: got vec=%0d v=%b want vec=1 v=1", vec_v[0], ov_v[0]);
      end
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      int n = 0;
      sel = 0;
      apply_reset();
      push_sweep(0, 3);
      ready_v[0] = 1'b1;
      pulse_start(0);
      while (cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (ov_v[0]) begin
            pop_check("pre_reset", n);
            n++;
            if (vec_v[0] == 8'd49) break;
         end
      end
      total++;
      if (n != 50) begin
         bad++;
         $display("FAIL reach_rec50: got %0d records want 50", n);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (obs_all !== 39'd0) begin
         bad++;
         $display("FAIL mid_reset: got %h want 0", obs_all);
      end
      exp_q.delete();
      push_sweep(0, 3);
      pulse_start(0);
      @(negedge clk);
      total++;
      if (ov_v[0] !== 1'b1) begin
         bad++;
         $display("FAIL restart_valid: got %b want 1", ov_v[0]);
      end
      pop_check("restart_first", 0);
      apply_reset();
   endtask

   task automatic test_single_op();
      sel = 1;
      ready_v[1] = 1'b1;
      push_sweep(3, 3);
      pulse_start(1);
      collect(49, 1'b0, 1'b1, 1'b1, 1'b0);
      check_done(8'd49, 4'd7);
   endtask

   initial begin
      rst = 1'b1;
      start_v[0] = 1'b0; start_v[1] = 1'b0;
      ready_v[0] = 1'b0; ready_v[1] = 1'b0;
      test_reset();
      test_full_sweep();
      test_start_ignored();
      test_stall();
      test_reset_mid();
      test_single_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
